mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 32, meaning address and data bus width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum cycles to wait for memory ACK; counter width = clog2(TIMEOUT_CYCLES+1).
REQ-003 SHALL have MEM_ARBITER_CLOCK_50  in  1  single system clock, rising edge.
REQ-004 SHALL have MEM_ARBITER_ResetInLow_In  in  1  asynchronous active-low reset.
REQ-005 SHALL have MEM_ARBITER_P0Req_In  in  1  port 0 (CPU control unit) access request.
REQ-006 SHALL have MEM_ARBITER_P0Wr_In  in  1  port 0 direction: 1 write, 0 read.
REQ-007 SHALL have MEM_ARBITER_P0Addr_InBus  in  DATAWIDTH_BUS  port 0 address.
REQ-008 SHALL have MEM_ARBITER_P0WData_InBus  in  DATAWIDTH_BUS  port 0 write data.
REQ-009 SHALL have MEM_ARBITER_P0Ack_Out  out  1  port 0 completion pulse.
REQ-010 SHALL have MEM_ARBITER_P1Req_In, P1Wr_In, P1Addr_InBus, P1WData_InBus, P1Ack_Out, identical to port 0, for port 1 (DMA/debug loader).
REQ-011 SHALL have MEM_ARBITER_RData_OutBus  out  DATAWIDTH_BUS  read data, valid in the cycle either Ack is high.
REQ-012 SHALL have MEM_ARBITER_Err_Out  out  1  timeout pulse, coincident with the granted port's Ack.
REQ-013 SHALL have MEM_ARBITER_MemRD_Out  out  1  read strobe to MAIN_MEMORY.
REQ-014 SHALL have MEM_ARBITER_MemWRMain_Out  out  1  write strobe to MAIN_MEMORY.
REQ-015 SHALL have MEM_ARBITER_MemA_OutBus  out  DATAWIDTH_BUS  memory address.
REQ-016 SHALL have MEM_ARBITER_MemB_OutBus  out  DATAWIDTH_BUS  memory write data.
REQ-017 SHALL have MEM_ARBITER_MemACK_In  in  1  memory acknowledge; MEM_ARBITER_MemData_InBus  in  DATAWIDTH_BUS  memory read data.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RELEASE.
REQ-019 IDLE: if any Req high, SHALL grant one port, latch its Wr/Addr/WData, clear timeout counter, go ACCESS next cycle; else stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: single request wins; on simultaneous requests the port not granted last wins; pointer favours port 0 after reset.
REQ-021 ACCESS: SHALL drive MemA/MemB from latched values and hold exactly one of MemRD/MemWRMain high (per latched Wr) until MemACK sampled high or timeout.
REQ-022 Latency: request sampled in IDLE at cycle n -> strobe high at cycle n+1; MemACK sampled at cycle m -> strobe low and Ack pulse at cycle m+1.
REQ-023 On MemACK in ACCESS: SHALL register MemData into RData (reads only; writes leave RData unchanged), pulse granted Ack for exactly 1 cycle, go RELEASE.
REQ-024 Timeout: counter increments each ACCESS cycle; at TIMEOUT_CYCLES without MemACK, SHALL drop strobes, pulse Ack and Err for 1 cycle, leave RData unchanged, go RELEASE.
REQ-025 RELEASE: strobes low; SHALL remain until MemACK low, then IDLE; guarantees at least one strobe-low cycle between accesses.
REQ-026 Requester deasserting Req mid-access SHALL NOT abort the access; latched address/data SHALL NOT change while not IDLE.
REQ-027 Requester holding Req after its Ack SHALL be re-arbitrated in the next IDLE like a new request.
REQ-028 MemRD and MemWRMain SHALL never be high simultaneously; Ack outputs SHALL never be high simultaneously.

Reset
REQ-029 On ResetInLow low (asynchronous): state IDLE, all strobes/Ack/Err 0, RData/MemA/MemB 0, counter 0, round-robin pointer = port 0; reset mid-access SHALL drop strobes immediately, with no Ack issued.
REQ-030 Release of reset SHALL resume operation on the first following rising clock edge.

Structure
REQ-031 FSM state encoding and port-id constants SHALL reside in a shared package with the other datapath/control constants.
REQ-032 Timeout counter MAY be a sub-module MEM_ARBITER_TIMER (load/clear, enable, terminal-count output); the rest is flat.

Verification
REQ-033 P0 read 0x00000010, memory ACK after 3 cycles with 0xDEADBEEF -> MemRD high 3 cycles, P0Ack 1 cycle, RData=0xDEADBEEF.
REQ-034 P0 and P1 request in same cycle, both held -> P0 granted first, then P1; repeat -> P1 first next round.
REQ-035 P1 write 0x0000002C <- 0x12345678 -> MemWRMain high, MemA=0x0000002C, MemB=0x12345678, MemRD stays 0, P1Ack pulse.
REQ-036 Memory never ACKs, TIMEOUT_CYCLES=8 -> strobe high 8 cycles, Ack and Err pulse together, FSM returns to IDLE.
REQ-037 Reset asserted during ACCESS -> strobes 0 asynchronously, no Ack; after release, new P0 request served normally.
REQ-038 MemACK held high 2 extra cycles -> FSM stays RELEASE until low; no second strobe or Ack meanwhile.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter:
// FSM encoding, port ids and round-robin helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DATAWIDTH_DEF = 32;
  localparam int TIMEOUT_DEF   = 255;

  // ptr names the favoured port on a tie
  function automatic logic rr_pick(
    input logic r0,
    input logic r1,
    input logic ptr
  );
    if (r0 && r1) return ptr;
    return r1 ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Access timeout counter: cleared while idle,
// counts ACCESS cycles, flags the last allowed one.
module mem_arbiter_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // cycle counter with clear priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of two ports
// a single read/write access to main memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DATAWIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                     MEM_ARBITER_CLOCK_50,
  input  logic                     MEM_ARBITER_ResetInLow_In,
  input  logic                     MEM_ARBITER_P0Req_In,
  input  logic                     MEM_ARBITER_P0Wr_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_P0Addr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_P0WData_InBus,
  output logic                     MEM_ARBITER_P0Ack_Out,
  input  logic                     MEM_ARBITER_P1Req_In,
  input  logic                     MEM_ARBITER_P1Wr_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_P1Addr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_P1WData_InBus,
  output logic                     MEM_ARBITER_P1Ack_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_RData_OutBus,
  output logic                     MEM_ARBITER_Err_Out,
  output logic                     MEM_ARBITER_MemRD_Out,
  output logic                     MEM_ARBITER_MemWRMain_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemA_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemB_OutBus,
  input  logic                     MEM_ARBITER_MemACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemData_InBus
);

  logic clk;
  logic rst_n;
  logic mem_ack;
  logic tc;

  assign clk     = MEM_ARBITER_CLOCK_50;
  assign rst_n   = MEM_ARBITER_ResetInLow_In;
  assign mem_ack = MEM_ARBITER_MemACK_In;

  state_t state_q, state_d;
  logic   rd_q, rd_d;
  logic   wr_q, wr_d;
  logic   ack0_q, ack0_d;
  logic   ack1_q, ack1_d;
  logic   err_q, err_d;
  logic   grant_q, grant_d;
  logic   ptr_q, ptr_d;
  logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;
  logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;

  logic g;
  logic wsel;

  mem_arbiter_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == S_IDLE),
    .en   (state_q == S_ACCESS),
    .tc   (tc)
  );

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      grant_q <= PORT0;
      ptr_q   <= PORT0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // next state: grant, hold strobe, finish, wait ack low
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    g       = rr_pick(MEM_ARBITER_P0Req_In,
                      MEM_ARBITER_P1Req_In, ptr_q);
    wsel    = g ? MEM_ARBITER_P1Wr_In
                : MEM_ARBITER_P0Wr_In;
    unique case (state_q)
      S_IDLE: begin
        if (MEM_ARBITER_P0Req_In ||
            MEM_ARBITER_P1Req_In) begin
          grant_d = g;
          ptr_d   = ~g;
          addr_d  = g ? MEM_ARBITER_P1Addr_InBus
                      : MEM_ARBITER_P0Addr_InBus;
          wdata_d = g ? MEM_ARBITER_P1WData_InBus
                      : MEM_ARBITER_P0WData_InBus;
          rd_d    = ~wsel;
          wr_d    = wsel;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ack || tc) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack0_d  = (grant_q == PORT0);
          ack1_d  = (grant_q == PORT1);
          state_d = S_RELEASE;
          if (mem_ack) begin
            if (rd_q) rdata_d = MEM_ARBITER_MemData_InBus;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (!mem_ack) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  assign MEM_ARBITER_P0Ack_Out     = ack0_q;
  assign MEM_ARBITER_P1Ack_Out     = ack1_q;
  assign MEM_ARBITER_Err_Out       = err_q;
  assign MEM_ARBITER_RData_OutBus  = rdata_q;
  assign MEM_ARBITER_MemRD_Out     = rd_q;
  assign MEM_ARBITER_MemWRMain_Out = wr_q;
  assign MEM_ARBITER_MemA_OutBus   = addr_q;
  assign MEM_ARBITER_MemB_OutBus   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector
// table plus timeout and async-reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0, w0, r1, w1, mack;
  logic [31:0] a0, d0, a1, d1, mdata;
  logic        ack0, ack1, err, rd, wr;
  logic [31:0] rdata, ma, mb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATAWIDTH_BUS (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .MEM_ARBITER_CLOCK_50     (clk),
    .MEM_ARBITER_ResetInLow_In(rst_n),
    .MEM_ARBITER_P0Req_In     (r0),
    .MEM_ARBITER_P0Wr_In      (w0),
    .MEM_ARBITER_P0Addr_InBus (a0),
    .MEM_ARBITER_P0WData_InBus(d0),
    .MEM_ARBITER_P0Ack_Out    (ack0),
    .MEM_ARBITER_P1Req_In     (r1),
    .MEM_ARBITER_P1Wr_In      (w1),
    .MEM_ARBITER_P1Addr_InBus (a1),
    .MEM_ARBITER_P1WData_InBus(d1),
    .MEM_ARBITER_P1Ack_Out    (ack1),
    .MEM_ARBITER_RData_OutBus (rdata),
    .MEM_ARBITER_Err_Out      (err),
    .MEM_ARBITER_MemRD_Out    (rd),
    .MEM_ARBITER_MemWRMain_Out(wr),
    .MEM_ARBITER_MemA_OutBus  (ma),
    .MEM_ARBITER_MemB_OutBus  (mb),
    .MEM_ARBITER_MemACK_In    (mack),
    .MEM_ARBITER_MemData_InBus(mdata)
  );

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        mack;
    logic [31:0] mdata;
    logic        rd, wr, ack0, ack1, err;
    logic [31:0] rdata, ma, mb;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(
    input logic i_r0, input logic i_w0,
    input logic [31:0] i_a0, input logic [31:0] i_d0,
    input logic i_r1, input logic i_w1,
    input logic [31:0] i_a1, input logic [31:0] i_d1,
    input logic i_mack, input logic [31:0] i_mdata,
    input logic e_rd, input logic e_wr,
    input logic e_ack0, input logic e_ack1,
    input logic e_err, input logic [31:0] e_rdata,
    input logic [31:0] e_ma, input logic [31:0] e_mb);
    vec_t v;
    v.r0 = i_r0; v.w0 = i_w0; v.a0 = i_a0; v.d0 = i_d0;
    v.r1 = i_r1; v.w1 = i_w1; v.a1 = i_a1; v.d1 = i_d1;
    v.mack = i_mack; v.mdata = i_mdata;
    v.rd = e_rd; v.wr = e_wr;
    v.ack0 = e_ack0; v.ack1 = e_ack1; v.err = e_err;
    v.rdata = e_rdata; v.ma = e_ma; v.mb = e_mb;
    vt.push_back(v);
  endtask

  task automatic idle_in();
    r0 = 0; w0 = 0; a0 = '0; d0 = '0;
    r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    mack = 0; mdata = '0;
  endtask

  task automatic chk_excl(input string nm);
    chk({nm, " rd&wr"}, {31'd0, rd & wr}, 32'd0);
    chk({nm, " ack0&ack1"}, {31'd0, ack0 & ack1}, 32'd0);
  endtask

  int n;

  initial begin
    // tie: P0 first, then P1, then P0 again
    add(1,0,32'h100,0, 1,1,32'h200,32'h11111111, 0,0,
        1,0,0,0,0, 32'h0, 32'h100, 32'h0);
    add(1,0,32'h100,0, 1,1,32'h200,32'h11111111, 1,32'hCAFE0001,
        0,0,1,0,0, 32'hCAFE0001, 32'h100, 32'h0);
    add(1,0,32'h100,0, 1,1,32'h200,32'h11111111, 0,0,
        0,0,0,0,0, 32'hCAFE0001, 32'h100, 32'h0);
    add(1,0,32'h100,0, 1,1,32'h200,32'h11111111, 0,0,
        0,1,0,0,0, 32'hCAFE0001, 32'h200, 32'h11111111);
    add(1,0,32'h100,0, 1,1,32'h200,32'h11111111, 1,32'h99,
        0,0,0,1,0, 32'hCAFE0001, 32'h200, 32'h11111111);
    add(1,0,32'h100,0, 1,1,32'h200,32'h11111111, 0,0,
        0,0,0,0,0, 32'hCAFE0001, 32'h200, 32'h11111111);
    add(1,0,32'h100,0, 1,1,32'h200,32'h11111111, 0,0,
        1,0,0,0,0, 32'hCAFE0001, 32'h100, 32'h0);
    add(0,0,0,0, 0,0,0,0, 1,32'hCAFE0002,
        0,0,1,0,0, 32'hCAFE0002, 32'h100, 32'h0);
    add(0,0,0,0, 0,0,0,0, 0,0,
        0,0,0,0,0, 32'hCAFE0002, 32'h100, 32'h0);
    // P0 read, ack on third strobe cycle, inputs wiggle
    add(1,0,32'h10,0, 0,0,0,0, 0,0,
        1,0,0,0,0, 32'hCAFE0002, 32'h10, 32'h0);
    add(0,1,32'hFFFF,32'hEEEE, 0,0,0,0, 0,0,
        1,0,0,0,0, 32'hCAFE0002, 32'h10, 32'h0);
    add(0,1,32'hFFFF,32'hEEEE, 0,0,0,0, 0,0,
        1,0,0,0,0, 32'hCAFE0002, 32'h10, 32'h0);
    add(0,0,0,0, 0,0,0,0, 1,32'hDEADBEEF,
        0,0,1,0,0, 32'hDEADBEEF, 32'h10, 32'h0);
    add(0,0,0,0, 0,0,0,0, 0,0,
        0,0,0,0,0, 32'hDEADBEEF, 32'h10, 32'h0);
    // P1 write leaves read data alone
    add(0,0,0,0, 1,1,32'h2C,32'h12345678, 0,0,
        0,1,0,0,0, 32'hDEADBEEF, 32'h2C, 32'h12345678);
    add(0,0,0,0, 0,0,32'h3C,0, 1,32'h55555555,
        0,0,0,1,0, 32'hDEADBEEF, 32'h2C, 32'h12345678);
    add(0,0,0,0, 0,0,0,0, 0,0,
        0,0,0,0,0, 32'hDEADBEEF, 32'h2C, 32'h12345678);
    // ack held long, P0 re-requesting meanwhile
    add(1,0,32'h40,0, 0,0,0,0, 0,0,
        1,0,0,0,0, 32'hDEADBEEF, 32'h40, 32'h0);
    add(0,0,0,0, 0,0,0,0, 1,32'hA5A5A5A5,
        0,0,1,0,0, 32'hA5A5A5A5, 32'h40, 32'h0);
    add(1,0,32'h50,0, 0,0,0,0, 1,32'h0,
        0,0,0,0,0, 32'hA5A5A5A5, 32'h40, 32'h0);
    add(1,0,32'h50,0, 0,0,0,0, 1,32'h0,
        0,0,0,0,0, 32'hA5A5A5A5, 32'h40, 32'h0);
    add(1,0,32'h50,0, 0,0,0,0, 0,0,
        0,0,0,0,0, 32'hA5A5A5A5, 32'h40, 32'h0);
    add(1,0,32'h50,0, 0,0,0,0, 0,0,
        1,0,0,0,0, 32'hA5A5A5A5, 32'h50, 32'h0);
    add(0,0,0,0, 0,0,0,0, 1,32'h0BADF00D,
        0,0,1,0,0, 32'h0BADF00D, 32'h50, 32'h0);
    add(0,0,0,0, 0,0,0,0, 0,0,
        0,0,0,0,0, 32'h0BADF00D, 32'h50, 32'h0);

    rst_n = 0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd", {31'd0, rd}, 32'd0);
    chk("reset wr", {31'd0, wr}, 32'd0);
    chk("reset ack0", {31'd0, ack0}, 32'd0);
    chk("reset ack1", {31'd0, ack1}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset mema", ma, 32'd0);
    chk("reset memb", mb, 32'd0);
    @(negedge clk);
    rst_n = 1;

    foreach (vt[i]) begin
      @(negedge clk);
      r0 = vt[i].r0; w0 = vt[i].w0;
      a0 = vt[i].a0; d0 = vt[i].d0;
      r1 = vt[i].r1; w1 = vt[i].w1;
      a1 = vt[i].a1; d1 = vt[i].d1;
      mack = vt[i].mack; mdata = vt[i].mdata;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d rd", i), {31'd0, rd}, {31'd0, vt[i].rd});
      chk($sformatf("row%0d wr", i), {31'd0, wr}, {31'd0, vt[i].wr});
      chk($sformatf("row%0d ack0", i), {31'd0, ack0}, {31'd0, vt[i].ack0});
      chk($sformatf("row%0d ack1", i), {31'd0, ack1}, {31'd0, vt[i].ack1});
      chk($sformatf("row%0d err", i), {31'd0, err}, {31'd0, vt[i].err});
      chk($sformatf("row%0d rdata", i), rdata, vt[i].rdata);
      chk($sformatf("row%0d mema", i), ma, vt[i].ma);
      chk($sformatf("row%0d memb", i), mb, vt[i].mb);
      chk_excl($sformatf("row%0d", i));
    end

    // timeout: memory never answers a P0 write
    @(negedge clk);
    idle_in();
    r0 = 1; w0 = 1; a0 = 32'h80; d0 = 32'hFEEDFACE;
    @(posedge clk);
    #1;
    r0 = 0;
    n = 0;
    while (wr && n < 20) begin
      chk_excl("timeout");
      chk("timeout early ack0", {31'd0, ack0}, 32'd0);
      n++;
      @(posedge clk);
      #1;
    end
    chk("timeout strobe cycles", n, 32'd8);
    chk("timeout ack0", {31'd0, ack0}, 32'd1);
    chk("timeout err", {31'd0, err}, 32'd1);
    chk("timeout rd", {31'd0, rd}, 32'd0);
    chk("timeout rdata", rdata, 32'h0BADF00D);
    chk("timeout mema", ma, 32'h80);
    chk("timeout memb", mb, 32'hFEEDFACE);
    @(posedge clk);
    #1;
    chk("timeout ack0 pulse", {31'd0, ack0}, 32'd0);
    chk("timeout err pulse", {31'd0, err}, 32'd0);

    // async reset in the middle of a P1 read
    @(negedge clk);
    r1 = 1; w1 = 0; a1 = 32'h90;
    @(posedge clk);
    #1;
    chk("pre-reset rd", {31'd0, rd}, 32'd1);
    r1 = 0;
    #2;
    rst_n = 0;
    #1;
    chk("async rd", {31'd0, rd}, 32'd0);
    chk("async wr", {31'd0, wr}, 32'd0);
    chk("async mema", ma, 32'd0);
    chk("async rdata", rdata, 32'd0);
    mack = 1; mdata = 32'h1234;
    @(posedge clk);
    #1;
    chk("reset no ack1", {31'd0, ack1}, 32'd0);
    chk("reset no ack0", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    mack = 0;
    @(negedge clk);
    r0 = 1; w0 = 0; a0 = 32'h60;
    @(posedge clk);
    #1;
    chk("post-reset rd", {31'd0, rd}, 32'd1);
    chk("post-reset mema", ma, 32'h60);
    @(negedge clk);
    r0 = 0; mack = 1; mdata = 32'h77;
    @(posedge clk);
    #1;
    chk("post-reset ack0", {31'd0, ack0}, 32'd1);
    chk("post-reset ack1", {31'd0, ack1}, 32'd0);
    chk("post-reset rdata", rdata, 32'h77);
    @(negedge clk);
    mack = 0;
    @(posedge clk);
    #1;
    chk("post-reset ack0 pulse", {31'd0, ack0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
